// File: rtl/glad_port_arbiter.sv
// Shares the single glad buffer RAM port between the DAQ stream (priority) and the host slave.
// Grant is same-cycle; host write latency 0, read data valid exactly 1 cycle after grant.
// Backpressure: st_ready / host_waitrequest; streak limit bounds host wait to MAX_STREAK cycles.
module glad_port_arbiter #(
    parameter int DEPTH      = 320,
    parameter int AW         = 9,
    parameter int MAX_STREAK = 4
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          st_valid,
    input  logic [15:0]   st_data,
    output logic          st_ready,
    input  logic          stream_enable,
    input  logic          frame_restart,
    input  logic [AW-1:0] host_address,
    input  logic          host_read,
    input  logic          host_write,
    input  logic [1:0]    host_byteenable,
    input  logic [15:0]   host_writedata,
    output logic          host_waitrequest,
    output logic [15:0]   host_readdata,
    output logic          host_readdatavalid,
    output logic [AW-1:0] ram_address,
    output logic [1:0]    ram_byteenable,
    output logic          ram_chipselect,
    output logic          ram_write,
    output logic [15:0]   ram_writedata,
    input  logic [15:0]   ram_readdata,
    output logic [AW-1:0] wr_ptr,
    output logic [15:0]   frame_count,
    output logic          frame_done
);

    localparam int SW = $clog2(MAX_STREAK + 1);
    localparam logic [AW:0]   DEPTH_W = (AW+1)'(DEPTH);
    localparam logic [AW-1:0] LAST    = AW'(DEPTH - 1);
    localparam logic [SW-1:0] SMAX    = SW'(MAX_STREAK);

    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [15:0]   frame_count_q, frame_count_d;
    logic          frame_done_q, frame_done_d;
    logic [SW-1:0] streak_q, streak_d;
    logic          rd_vld_q, rd_vld_d;
    logic          rd_ok_q, rd_ok_d;

    logic st_req, host_req, host_in_range, stream_gnt, host_gnt;

    always_comb begin
        st_req        = st_valid & stream_enable & ~frame_restart;
        host_req      = host_read | host_write;
        host_in_range = ({1'b0, host_address} < DEPTH_W);
        stream_gnt    = st_req & (~host_req | (streak_q != SMAX));
        host_gnt      = host_req & ~stream_gnt;

        st_ready         = stream_gnt;
        host_waitrequest = ~host_gnt;
        ram_address      = '0;
        ram_byteenable   = 2'b00;
        ram_chipselect   = 1'b0;
        ram_write        = 1'b0;
        ram_writedata    = 16'h0000;

        wr_ptr_d      = wr_ptr_q;
        frame_count_d = frame_count_q;
        frame_done_d  = 1'b0;
        streak_d      = streak_q;

        if (stream_gnt) begin
            ram_address    = wr_ptr_q;
            ram_byteenable = 2'b11;
            ram_chipselect = 1'b1;
            ram_write      = 1'b1;
            ram_writedata  = st_data;
            if (wr_ptr_q == LAST) begin
                wr_ptr_d      = '0;
                frame_count_d = frame_count_q + 16'd1;
                frame_done_d  = 1'b1;
            end else begin
                wr_ptr_d = wr_ptr_q + 1'b1;
            end
        end else if (host_gnt) begin
            ram_address    = host_address;
            ram_byteenable = host_byteenable;
            ram_chipselect = host_in_range;
            ram_write      = host_write & host_in_range;
            ram_writedata  = host_writedata;
        end

        // restart never coincides with a stream grant, so it cannot lose a wrap
        if (frame_restart) begin
            wr_ptr_d = '0;
        end

        if (host_gnt || !host_req) begin
            streak_d = '0;
        end else if (stream_gnt && (streak_q != SMAX)) begin
            streak_d = streak_q + 1'b1;
        end

        // write wins when both strobes are (illegally) high
        rd_vld_d = host_gnt & host_read & ~host_write;
        rd_ok_d  = rd_vld_d & host_in_range;
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            wr_ptr_q      <= '0;
            frame_count_q <= 16'h0000;
            frame_done_q  <= 1'b0;
            streak_q      <= '0;
            rd_vld_q      <= 1'b0;
            rd_ok_q       <= 1'b0;
        end else begin
            wr_ptr_q      <= wr_ptr_d;
            frame_count_q <= frame_count_d;
            frame_done_q  <= frame_done_d;
            streak_q      <= streak_d;
            rd_vld_q      <= rd_vld_d;
            rd_ok_q       <= rd_ok_d;
        end
    end

    assign host_readdatavalid = rd_vld_q;
    assign host_readdata      = rd_ok_q ? ram_readdata : 16'h0000;
    assign wr_ptr             = wr_ptr_q;
    assign frame_count        = frame_count_q;
    assign frame_done         = frame_done_q;

endmodule
